// File: rtl/pmem_line_server.sv
// Line-granular physical memory model: one request at a time, fixed response latency, request counters.
// Optional PMEM_STALL_LFSR_EN adds a pseudo-random 0..7 cycle stall per request.
module pmem_line_server #(
  parameter int LINE_IDX_BITS = 9,
  parameter int LATENCY       = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic [31:0]  read_count,
  output logic [31:0]  write_count
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

  state_t                   state, state_nxt;
  logic [8:0]               cnt;
  logic [8:0]               cnt_load;
  logic                     op_write;
  logic [LINE_IDX_BITS-1:0] idx;
  logic [255:0]             wdata_q;
  logic                     accept;
  logic                     fire;
  logic [2:0]               extra;

  logic [255:0] mem [2**LINE_IDX_BITS];

  logic unused_addr;
  assign unused_addr = ^{pmem_address[31:LINE_IDX_BITS+5], pmem_address[4:0]};

`ifdef PMEM_STALL_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign extra = lfsr[2:0];
`else
  assign extra = '0;
`endif

  assign accept   = (state == IDLE) && (pmem_read || pmem_write);
  // Count reaches zero after LATENCY-1 decrements; the following edge enters RESP,
  // so accept at E0 gives pmem_resp in the cycle after E(LATENCY), LATENCY==1 included.
  assign fire     = (state == BUSY) && (cnt == '0);
  assign cnt_load = 9'(LATENCY - 1) + 9'(extra);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pmem_read || pmem_write) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_write    <= 1'b0;
      idx         <= '0;
      wdata_q     <= '0;
      pmem_resp   <= 1'b0;
      pmem_rdata  <= '0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      state     <= state_nxt;
      pmem_resp <= fire;
      if (accept) begin
        op_write <= pmem_write;
        idx      <= pmem_address[LINE_IDX_BITS+4:5];
        wdata_q  <= pmem_wdata;
        cnt      <= cnt_load;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 9'd1;
      end
      if (fire) begin
        if (op_write) begin
          write_count <= write_count + 32'd1;
        end else begin
          pmem_rdata <= mem[idx];
          read_count <= read_count + 32'd1;
        end
      end
    end
  end

  // Array has no reset; fire is low while in reset so dropped requests never write.
  always_ff @(posedge clk) begin
    if (fire && op_write) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_pmem_line_server.sv
// Directed bench for pmem_line_server: latency, data, counters, dual-request, aliasing, reset abort.
module tb_pmem_line_server;

  localparam int LAT = 10;

  logic         clk;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  read_count;
  logic [31:0]  write_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_lfsr = 8'hA5;

  pmem_line_server #(.LINE_IDX_BITS(9), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .read_count   (read_count),
    .write_count  (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected latency of the next accepted request; steps the stall model when enabled.
  task automatic next_latency(output int lat);
    lat = LAT;
`ifdef PMEM_STALL_LFSR_EN
    lat = lat + int'(m_lfsr[2:0]);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
  endtask

  // Issue a request, measure accept-to-resp latency, optionally keep it held after resp.
  task automatic serve(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wd, input int hold, output int lat, output int pulses);
    int n;
    bit got;
    n = 0;
    got = 0;
    pulses = 0;
    pmem_read = rd;
    pmem_write = wr;
    pmem_address = addr;
    pmem_wdata = wd;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (pmem_resp) got = 1;
    end
    lat = got ? n - 1 : -1;
    if (got) pulses = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (pmem_resp) pulses++;
    end
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = 32'hFFFF_FFE0;
    pmem_wdata = '1;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  logic [255:0] beef;
  logic [255:0] p5;
  int lat, exp_lat, pulses, n;
  bit got;

  initial begin
    beef = {8{32'hDEADBEEF}};
    p5   = {4{64'h0123_4567_89AB_CDEF}};
    rst_n = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp", 256'(pmem_resp), 256'd0);
    check("rst_rdata", pmem_rdata, 256'd0);
    check("rst_rcnt", 256'(read_count), 256'd0);
    check("rst_wcnt", 256'(write_count), 256'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: write, latency and write count
    next_latency(exp_lat);
    serve(1'b0, 1'b1, 32'h0000_0040, beef, 0, lat, pulses);
    check("t1_lat", 256'(lat), 256'(exp_lat));
    check("t1_wcnt", 256'(write_count), 256'd1);
    check("t1_rcnt", 256'(read_count), 256'd0);
    check("t1_rdata_untouched", pmem_rdata, 256'd0);

    // 2: read back
    next_latency(exp_lat);
    serve(1'b1, 1'b0, 32'h0000_0040, '0, 0, lat, pulses);
    check("t2_lat", 256'(lat), 256'(exp_lat));
    check("t2_rdata", pmem_rdata, beef);
    check("t2_rcnt", 256'(read_count), 256'd1);

    // 3: read held past resp: one pulse, one count; the re-accepted read is then drained
    next_latency(exp_lat);
    serve(1'b1, 1'b0, 32'h0000_0040, '0, 5, lat, pulses);
    check("t3_lat", 256'(lat), 256'(exp_lat));
    check("t3_pulses", 256'(pulses), 256'd1);
    check("t3_rcnt", 256'(read_count), 256'd2);
    next_latency(exp_lat);
    n = 0;
    got = 0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (pmem_resp) got = 1;
    end
    check("t3_drain_resp", 256'(got), 256'd1);
    @(posedge clk);
    @(posedge clk); #1;
    check("t3_drain_rcnt", 256'(read_count), 256'd3);

    // 4: read+write together acts as write
    next_latency(exp_lat);
    serve(1'b1, 1'b1, 32'h0000_0080, 256'h1, 0, lat, pulses);
    check("t4_lat", 256'(lat), 256'(exp_lat));
    check("t4_wcnt", 256'(write_count), 256'd2);
    check("t4_rcnt", 256'(read_count), 256'd3);
    check("t4_rdata_hold", pmem_rdata, beef);
    next_latency(exp_lat);
    serve(1'b1, 1'b0, 32'h0000_0080, '0, 0, lat, pulses);
    check("t4_rdata", pmem_rdata, 256'h1);
    check("t4_rcnt2", 256'(read_count), 256'd4);

    // 5: address aliasing modulo 512 lines
    next_latency(exp_lat);
    serve(1'b0, 1'b1, 32'h0000_4020, p5, 0, lat, pulses);
    check("t5_wcnt", 256'(write_count), 256'd3);
    next_latency(exp_lat);
    serve(1'b1, 1'b0, 32'h0000_0020, '0, 0, lat, pulses);
    check("t5_rdata", pmem_rdata, p5);
    check("t5_rcnt", 256'(read_count), 256'd5);

    // 6: reset during BUSY drops the write
    pmem_write = 1'b1;
    pmem_address = 32'h0000_0040;
    pmem_wdata = 256'hBAD;
    @(posedge clk); #1;
    pmem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_resp", 256'(pmem_resp), 256'd0);
    check("t6_rst_rdata", pmem_rdata, 256'd0);
    check("t6_rst_wcnt", 256'(write_count), 256'd0);
    check("t6_rst_rcnt", 256'(read_count), 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_lfsr = 8'hA5;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pmem_resp) pulses++;
    end
    check("t6_no_resp", 256'(pulses), 256'd0);
    check("t6_wcnt_after", 256'(write_count), 256'd0);

    // 7: first accept after reset; line 0x40 still holds the earlier data
    next_latency(exp_lat);
    serve(1'b1, 1'b0, 32'h0000_0040, '0, 0, lat, pulses);
    check("t7_first_lat", 256'(lat), 256'(exp_lat));
    check("t6_line_kept", pmem_rdata, beef);
    check("t7_rcnt", 256'(read_count), 256'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
